// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle between the core and the mul/div unit
interface mul_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wr_data;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, src_a, src_b, hi_we, lo_we, wr_data,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, src_a, src_b, hi_we, lo_we, wr_data,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers (option: MULDIV_ZERO_SHORTCUT_EN)
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   mul_div_unit_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]         state;
   logic [CW-1:0]      count;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   a_raw;
   logic               div_zero;
   logic               res_neg;
   logic               rem_neg;
   logic [2*WIDTH-1:0] work;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic               in_signed;
   logic               in_sign_a;
   logic               in_sign_b;
   logic [WIDTH-1:0]   in_mag_a;
   logic [WIDTH-1:0]   in_mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH-1:0]   rem_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] work_next;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   assign bus.busy = (state != IDLE);
   assign bus.done = (state == DONE);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

   // operand magnitudes at launch; -2^31 negates to itself, which reads correctly as unsigned
   always_comb begin
      in_signed = ~bus.op[0];
      in_sign_a = in_signed & bus.src_a[WIDTH-1];
      in_sign_b = in_signed & bus.src_b[WIDTH-1];
      in_mag_a  = in_sign_a ? (~bus.src_a + 1'b1) : bus.src_a;
      in_mag_b  = in_sign_b ? (~bus.src_b + 1'b1) : bus.src_b;
   end

   // one shift-add (mul) or restoring shift-subtract (div) step on {upper, lower}
   always_comb begin
      mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, a_mag} : '0);
      rem_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
      div_ge    = (rem_shift >= {1'b0, b_mag});
      rem_diff  = rem_shift[WIDTH-1:0] - b_mag;
      if (op_q[1]) begin
         work_next = {(div_ge ? rem_diff : rem_shift[WIDTH-1:0]), work[WIDTH-2:0], div_ge};
      end else begin
         work_next = {mul_sum, work[WIDTH-1:1]};
      end
   end

   // sign fix-up of the final step; divide by zero returns the raw dividend in HI
   always_comb begin
      prod = res_neg ? (~work_next + 1'b1) : work_next;
      if (!op_q[1]) begin
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end else if (div_zero) begin
         res_hi = a_raw;
         res_lo = '1;
      end else begin
         res_hi = rem_neg ? (~work_next[2*WIDTH-1:WIDTH] + 1'b1) : work_next[2*WIDTH-1:WIDTH];
         res_lo = res_neg ? (~work_next[WIDTH-1:0] + 1'b1) : work_next[WIDTH-1:0];
      end
   end

   // control FSM, operand capture, iteration and HI/LO update
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         count    <= '0;
         op_q     <= '0;
         a_mag    <= '0;
         b_mag    <= '0;
         a_raw    <= '0;
         div_zero <= 1'b0;
         res_neg  <= 1'b0;
         rem_neg  <= 1'b0;
         work     <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.hi_we) hi_q <= bus.wr_data;
               if (bus.lo_we) lo_q <= bus.wr_data;
               if (bus.start) begin
                  op_q     <= bus.op;
                  a_mag    <= in_mag_a;
                  b_mag    <= in_mag_b;
                  a_raw    <= bus.src_a;
                  div_zero <= (bus.src_b == '0);
                  res_neg  <= in_sign_a ^ in_sign_b;
                  rem_neg  <= in_sign_a;
                  work     <= {{WIDTH{1'b0}}, (bus.op[1] ? in_mag_a : in_mag_b)};
                  count    <= '0;
`ifdef MULDIV_ZERO_SHORTCUT_EN
                  if (bus.op[1] ? (bus.src_b == '0) : ((bus.src_a == '0) || (bus.src_b == '0))) begin
                     state <= DONE;
                     hi_q  <= bus.op[1] ? bus.src_a : '0;
                     lo_q  <= bus.op[1] ? '1 : '0;
                  end else begin
                     state <= RUN;
                  end
`else
                  state <= RUN;
`endif
               end
            end
            RUN: begin
               work  <= work_next;
               count <= count + 1'b1;
               if (count == CW'(WIDTH-1)) begin
                  state <= DONE;
                  hi_q  <= res_hi;
                  lo_q  <= res_lo;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   typedef struct {
      logic [63:0] res;
      int          lat;
   } exp_t;

   vec_t vecs[11];
   exp_t sb_q[$];

   mul_div_unit_if bus ();

   mul_div_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      int sa;
      int sb;
      sa = a;
      sb = b;
      case (op)
         2'b00: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
         2'b01: p = {32'h0, a} * {32'h0, b};
         2'b10: begin
            if (b == 32'h0) p = {a, 32'hFFFFFFFF};
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'h0, 32'h80000000};
            else p = {32'(sa % sb), 32'(sa / sb)};
         end
         default: begin
            if (b == 32'h0) p = {a, 32'hFFFFFFFF};
            else p = {a % b, a / b};
         end
      endcase
      return p;
   endfunction

   function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_ZERO_SHORTCUT_EN
      if (op[1] ? (b == 32'h0) : (a == 32'h0 || b == 32'h0)) return 1;
`endif
      return 33;
   endfunction

   // drive one op, then count cycles to done and compare against the scoreboard head
   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] res);
      exp_t e;
      int   k;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.src_a = a;
      bus.src_b = b;
      sb_q.push_back('{res: res, lat: exp_lat(op, a, b)});
      @(negedge clk);
      bus.start = 1'b0;
      k = 1;
      while (!bus.done && k < 40) begin
         @(negedge clk);
         k++;
      end
      e = sb_q.pop_front();
      chk({name, "_done_seen"}, 64'(bus.done), 64'(1));
      chk({name, "_latency"}, 64'(k), 64'(e.lat));
      chk({name, "_hi"}, 64'(bus.hi), 64'(e.res[63:32]));
      chk({name, "_lo"}, 64'(bus.lo), 64'(e.res[31:0]));
      @(negedge clk);
      chk({name, "_idle_after"}, 64'(bus.busy), 64'(0));
   endtask

   initial begin
      int n_done;
      int done_k;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [1:0]  rop;

      checks   = 0;
      failures = 0;

      vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{2'b11, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF};
      vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[7]  = '{2'b00, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000};
      vecs[8]  = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
      vecs[9]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[10] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.op      = 2'b00;
      bus.src_a   = '0;
      bus.src_b   = '0;
      bus.hi_we   = 1'b0;
      bus.lo_we   = 1'b0;
      bus.wr_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_busy", 64'(bus.busy), 64'(0));
      chk("reset_done", 64'(bus.done), 64'(0));
      chk("reset_hi", 64'(bus.hi), 64'(0));
      chk("reset_lo", 64'(bus.lo), 64'(0));

      // MTLO then MTHI in IDLE
      bus.lo_we   = 1'b1;
      bus.wr_data = 32'h00001234;
      @(negedge clk);
      bus.lo_we = 1'b0;
      chk("mtlo_lo", 64'(bus.lo), 64'h1234);
      chk("mtlo_hi_untouched", 64'(bus.hi), 64'(0));
      bus.hi_we   = 1'b1;
      bus.wr_data = 32'hCAFE0001;
      @(negedge clk);
      bus.hi_we = 1'b0;
      chk("mthi_hi", 64'(bus.hi), 64'hCAFE0001);
      chk("mthi_lo_untouched", 64'(bus.lo), 64'h1234);

      for (int i = 0; i < 11; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});
      end

      for (int i = 0; i < 8; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i[0]) ? 32'($urandom_range(1, 300)) : $urandom;
         if (i[1:0] == 2'b10 && rop[1]) ra[31] = 1'b1;
         run_op($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb));
      end

      // MTHI together with start: write lands now, result overwrites at completion
      @(negedge clk);
      bus.hi_we   = 1'b1;
      bus.wr_data = 32'h0000ABCD;
      bus.start   = 1'b1;
      bus.op      = 2'b01;
      bus.src_a   = 32'd3;
      bus.src_b   = 32'd4;
      @(negedge clk);
      bus.hi_we = 1'b0;
      bus.start = 1'b0;
      chk("we_start_hi_written", 64'(bus.hi), 64'hABCD);
      done_k = 1;
      while (!bus.done && done_k < 40) begin
         @(negedge clk);
         done_k++;
      end
      chk("we_start_latency", 64'(done_k), 64'(33));
      chk("we_start_hi", 64'(bus.hi), 64'(0));
      chk("we_start_lo", 64'(bus.lo), 64'd12);
      @(negedge clk);

      // start + MTHI during RUN are both ignored
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 2'b01;
      bus.src_a = 32'hFFFFFFFF;
      bus.src_b = 32'hFFFFFFFF;
      sb_q.push_back('{res: 64'hFFFFFFFE_00000001, lat: 33});
      n_done = 0;
      done_k = 0;
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.hi_we = 1'b0;
         if (bus.done) begin
            n_done++;
            done_k = k;
            if (n_done == 1) begin
               chk("ignore_hi", 64'(bus.hi), 64'(sb_q[0].res[63:32]));
               chk("ignore_lo", 64'(bus.lo), 64'(sb_q[0].res[31:0]));
               void'(sb_q.pop_front());
            end
         end
         if (k == 5) begin
            bus.start   = 1'b1;
            bus.op      = 2'b00;
            bus.src_a   = 32'd5;
            bus.src_b   = 32'd5;
            bus.hi_we   = 1'b1;
            bus.wr_data = 32'hDEADBEEF;
         end
      end
      chk("ignore_done_count", 64'(n_done), 64'(1));
      chk("ignore_done_cycle", 64'(done_k), 64'(33));
      chk("ignore_hi_final", 64'(bus.hi), 64'hFFFFFFFE);

      // reset in the middle of a MULT
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 2'b00;
      bus.src_a = 32'd3;
      bus.src_b = 32'd5;
      n_done = 0;
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.done) n_done++;
         if (k == 10) rst_n = 1'b0;
         if (k == 11) begin
            rst_n = 1'b1;
            chk("midreset_busy", 64'(bus.busy), 64'(0));
            chk("midreset_hi", 64'(bus.hi), 64'(0));
            chk("midreset_lo", 64'(bus.lo), 64'(0));
         end
      end
      chk("midreset_no_done", 64'(n_done), 64'(0));
      chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
